// File: rtl/fetch_align.sv
// fetch_align: instruction fetch alignment and RV32C expansion.
//
// Sits between the instruction-memory response port and decode. Each fetched
// 32-bit word is split into halfwords and placed in a 4-entry halfword queue.
// The head of the queue is decoded combinationally into one 16- or 32-bit
// instruction. A 32-bit instruction may straddle two fetched words.
// Compressed encodings are expanded to their 32-bit equivalents.
//
// Ports
//   clock, reset         core clock and asynchronous active-low reset
//   flush_i, flush_pc_i  redirect; drops queued and in-flight data, bit0 of target forced 0
//   fetch_*_i            memory response word, its word address and its access-fault flag
//   fetch_ready_o        the queue has room for a whole word (count <= 2)
//   instr_valid_o/ready_i  handshake to decode, one instruction per transfer
//   instr_o, instr_pc_o  expanded instruction and its PC
//   instr_compressed_o   the source encoding was 16-bit
//   instr_illegal_o      reserved/unsupported compressed encoding; instr_o = {16'h0, halfword}
//   instr_fault_o        a halfword of the instruction faulted; instr_o = nop
module fetch_align #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_addr_i,
    input  logic [31:0] fetch_rdata_i,
    input  logic        fetch_error_i,
    output logic        fetch_ready_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_compressed_o,
    output logic        instr_illegal_o,
    output logic        instr_fault_o
);

    localparam logic [31:0] NopInstr = 32'h0000_0013;
    localparam logic [6:0]  OpcLoad  = 7'h03;
    localparam logic [6:0]  OpcImm   = 7'h13;
    localparam logic [6:0]  OpcStore = 7'h23;
    localparam logic [6:0]  OpcOp    = 7'h33;
    localparam logic [6:0]  OpcLui   = 7'h37;
    localparam logic [6:0]  OpcBr    = 7'h63;
    localparam logic [6:0]  OpcJalr  = 7'h67;
    localparam logic [6:0]  OpcJal   = 7'h6f;

    // Queue and control state
    logic [15:0] q_data_q [4];
    logic [15:0] q_data_d [4];
    logic [3:0]  q_err_q, q_err_d;
    logic [2:0]  count_q, count_d;
    logic [1:0]  rptr_q, rptr_d;
    logic [1:0]  wptr_q, wptr_d;
    logic [31:0] exp_addr_q, exp_addr_d;
    logic [31:0] head_pc_q, head_pc_d;

    logic        addr_match, accept, head_avail, is_32, fire, fault;
    logic [1:0]  push_n, pop_n, rptr_nx, wptr_nx;
    logic [15:0] hw0, hw1;
    logic        err0, err1;

    // Bits that are deliberately ignored
    logic unused_bits;
    assign unused_bits = ^{fetch_addr_i[1:0], flush_pc_i[0], exp_addr_q[0]};

    assign fetch_ready_o = (count_q <= 3'd2);
    assign addr_match    = (fetch_addr_i[31:2] == exp_addr_q[31:2]);
    assign accept        = fetch_valid_i & fetch_ready_o & ~flush_i;

    assign rptr_nx = rptr_q + 2'd1;
    assign wptr_nx = wptr_q + 2'd1;
    assign hw0     = q_data_q[rptr_q];
    assign hw1     = q_data_q[rptr_nx];
    assign err0    = q_err_q[rptr_q];
    assign err1    = q_err_q[rptr_nx];

    // A faulted low halfword is never length-decoded: it retires as one 16-bit slot.
    assign is_32      = (hw0[1:0] == 2'b11) & ~err0;
    assign head_avail = is_32 ? (count_q >= 3'd2) : (count_q >= 3'd1);
    assign fault      = err0 | (is_32 & err1);
    assign fire       = head_avail & instr_ready_i & ~flush_i;

    always_comb begin
        push_n = 2'd0;
        if (accept && addr_match) begin
            push_n = exp_addr_q[1] ? 2'd1 : 2'd2;
        end
        pop_n = 2'd0;
        if (fire) begin
            pop_n = is_32 ? 2'd2 : 2'd1;
        end
    end

    // Next-state logic
    always_comb begin
        q_data_d   = q_data_q;
        q_err_d    = q_err_q;
        wptr_d     = wptr_q + push_n;
        rptr_d     = rptr_q + pop_n;
        count_d    = count_q + {1'b0, push_n} - {1'b0, pop_n};
        exp_addr_d = exp_addr_q;
        head_pc_d  = head_pc_q + {29'd0, pop_n, 1'b0};

        if (push_n == 2'd2) begin
            q_data_d[wptr_q]  = fetch_rdata_i[15:0];
            q_data_d[wptr_nx] = fetch_rdata_i[31:16];
            q_err_d[wptr_q]   = fetch_error_i;
            q_err_d[wptr_nx]  = fetch_error_i;
        end else if (push_n == 2'd1) begin
            // Entry at an odd halfword: only the upper half belongs to the stream.
            q_data_d[wptr_q]  = fetch_rdata_i[31:16];
            q_err_d[wptr_q]   = fetch_error_i;
        end
        if (push_n != 2'd0) begin
            exp_addr_d = {exp_addr_q[31:2] + 30'd1, 2'b00};
        end

        if (flush_i) begin
            count_d    = 3'd0;
            rptr_d     = 2'd0;
            wptr_d     = 2'd0;
            exp_addr_d = {flush_pc_i[31:1], 1'b0};
            head_pc_d  = {flush_pc_i[31:1], 1'b0};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                q_data_q[i] <= 16'h0;
            end
            q_err_q    <= 4'h0;
            count_q    <= 3'd0;
            rptr_q     <= 2'd0;
            wptr_q     <= 2'd0;
            exp_addr_q <= RESET_PC;
            head_pc_q  <= RESET_PC;
        end else begin
            q_data_q   <= q_data_d;
            q_err_q    <= q_err_d;
            count_q    <= count_d;
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
            exp_addr_q <= exp_addr_d;
            head_pc_q  <= head_pc_d;
        end
    end

    // RV32C expansion of the head halfword
    logic [31:0] c_instr;
    logic        c_illegal;
    logic [4:0]  rdp, rs1p, c_rd;

    assign rdp  = {2'b01, hw0[4:2]};
    assign rs1p = {2'b01, hw0[9:7]};
    assign c_rd = hw0[11:7];

    always_comb begin
        c_instr   = NopInstr;
        c_illegal = 1'b0;
        case (hw0[1:0])
            2'b00: begin
                case (hw0[15:13])
                    3'b000: begin  // c.addi4spn
                        c_instr = {2'b00, hw0[10:7], hw0[12:11], hw0[5], hw0[6], 2'b00,
                                   5'd2, 3'b000, rdp, OpcImm};
                        c_illegal = (hw0[12:5] == 8'h00);
                    end
                    3'b010: c_instr = {5'b0, hw0[5], hw0[12:10], hw0[6], 2'b00, rs1p, 3'b010,
                                       rdp, OpcLoad};  // c.lw
                    3'b110: c_instr = {5'b0, hw0[5], hw0[12], rdp, rs1p, 3'b010, hw0[11:10],
                                       hw0[6], 2'b00, OpcStore};  // c.sw
                    default: c_illegal = 1'b1;
                endcase
            end
            2'b01: begin
                case (hw0[15:13])
                    3'b000: c_instr = {{7{hw0[12]}}, hw0[6:2], c_rd, 3'b000, c_rd, OpcImm};
                    3'b001, 3'b101: begin  // c.jal / c.j
                        c_instr = {hw0[12], hw0[8], hw0[10:9], hw0[6], hw0[7], hw0[2], hw0[11],
                                   hw0[5:3], hw0[12], {8{hw0[12]}},
                                   hw0[15] ? 5'd0 : 5'd1, OpcJal};
                    end
                    3'b010: c_instr = {{7{hw0[12]}}, hw0[6:2], 5'd0, 3'b000, c_rd, OpcImm};
                    3'b011: begin
                        if (c_rd == 5'd2) begin  // c.addi16sp
                            c_instr = {{3{hw0[12]}}, hw0[4:3], hw0[5], hw0[2], hw0[6], 4'b0000,
                                       5'd2, 3'b000, 5'd2, OpcImm};
                        end else begin  // c.lui
                            c_instr = {{15{hw0[12]}}, hw0[6:2], c_rd, OpcLui};
                        end
                        c_illegal = ({hw0[12], hw0[6:2]} == 6'd0);
                    end
                    3'b100: begin
                        case (hw0[11:10])
                            2'b00: begin
                                c_instr   = {7'b0, hw0[6:2], rs1p, 3'b101, rs1p, OpcImm};
                                c_illegal = hw0[12];
                            end
                            2'b01: begin
                                c_instr   = {7'b0100000, hw0[6:2], rs1p, 3'b101, rs1p, OpcImm};
                                c_illegal = hw0[12];
                            end
                            2'b10: c_instr = {{7{hw0[12]}}, hw0[6:2], rs1p, 3'b111, rs1p, OpcImm};
                            default: begin
                                if (hw0[12]) begin
                                    c_illegal = 1'b1;
                                end else begin
                                    case (hw0[6:5])
                                        2'b00: c_instr = {7'b0100000, rdp, rs1p, 3'b000, rs1p, OpcOp};
                                        2'b01: c_instr = {7'b0, rdp, rs1p, 3'b100, rs1p, OpcOp};
                                        2'b10: c_instr = {7'b0, rdp, rs1p, 3'b110, rs1p, OpcOp};
                                        default: c_instr = {7'b0, rdp, rs1p, 3'b111, rs1p, OpcOp};
                                    endcase
                                end
                            end
                        endcase
                    end
                    default: begin  // c.beqz / c.bnez
                        c_instr = {{4{hw0[12]}}, hw0[6:5], hw0[2], 5'd0, rs1p, 2'b00, hw0[13],
                                   hw0[11:10], hw0[4:3], hw0[12], OpcBr};
                    end
                endcase
            end
            2'b10: begin
                case (hw0[15:13])
                    3'b000: begin
                        c_instr   = {7'b0, hw0[6:2], c_rd, 3'b001, c_rd, OpcImm};
                        c_illegal = hw0[12];
                    end
                    3'b010: begin  // c.lwsp
                        c_instr   = {4'b0, hw0[3:2], hw0[12], hw0[6:4], 2'b00, 5'd2, 3'b010,
                                     c_rd, OpcLoad};
                        c_illegal = (c_rd == 5'd0);
                    end
                    3'b100: begin
                        if (!hw0[12]) begin
                            if (hw0[6:2] == 5'd0) begin  // c.jr
                                c_instr   = {12'b0, c_rd, 3'b000, 5'd0, OpcJalr};
                                c_illegal = (c_rd == 5'd0);
                            end else begin  // c.mv
                                c_instr = {7'b0, hw0[6:2], 5'd0, 3'b000, c_rd, OpcOp};
                            end
                        end else if (hw0[11:2] == 10'd0) begin
                            c_instr = 32'h0010_0073;  // ebreak
                        end else if (hw0[6:2] == 5'd0) begin  // c.jalr
                            c_instr = {12'b0, c_rd, 3'b000, 5'd1, OpcJalr};
                        end else begin  // c.add
                            c_instr = {7'b0, hw0[6:2], c_rd, 3'b000, c_rd, OpcOp};
                        end
                    end
                    3'b110: c_instr = {4'b0, hw0[8:7], hw0[12], hw0[6:2], 5'd2, 3'b010,
                                       hw0[11:9], 2'b00, OpcStore};  // c.swsp
                    default: c_illegal = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

    // Output mux
    always_comb begin
        instr_valid_o      = head_avail;
        instr_pc_o         = head_pc_q;
        instr_o            = NopInstr;
        instr_compressed_o = 1'b0;
        instr_illegal_o    = 1'b0;
        instr_fault_o      = 1'b0;
        if (head_avail) begin
            instr_compressed_o = ~is_32;
            if (fault) begin
                instr_fault_o = 1'b1;
            end else if (is_32) begin
                instr_o = {hw1, hw0};
            end else if (c_illegal) begin
                instr_illegal_o = 1'b1;
                instr_o         = {16'h0000, hw0};
            end else begin
                instr_o = c_instr;
            end
        end
    end

endmodule
